// File: rtl/dmem_bridge.sv
// dmem_bridge: bridges the core's M-stage load/store requests onto a
// valid/ready request bus with a separate read-response channel.
// Loads wait for a response, with a timeout of RESP_TIMEOUT WAIT cycles.
// Optional feature macro: DMEM_BRIDGE_POSTED_WRITE_EN. When it is defined,
// stores are posted into the request registers, which act as a 1-entry
// write buffer, so the core does not stall for them.
module dmem_bridge #(
  parameter int unsigned RESP_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  byteEnable,
  output logic [31:0] RD_data,
  output logic        MemStall,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_req_we,
  output logic [31:0] bus_req_addr,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_be,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_resp_rdata,
  output logic        bus_err
);

  localparam int unsigned CNT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [31:0]      r_rd_data;
  logic             r_err;
  logic [CNT_W-1:0] r_wait_cnt;

  logic [1:0]       w_state_next;
  logic             w_stall;
  logic             w_capture;
  logic             w_rd_load;
  logic             w_timeout;
  logic             w_access;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_access  = MemReadM | MemWriteM;
  assign w_cnt_inc = r_wait_cnt + CNT_W'(1);

  // Next-state, stall and datapath-strobe decode
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_capture    = 1'b0;
    w_rd_load    = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_next   = r_wait_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          w_capture    = 1'b1;
          w_state_next = S_REQ;
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
          // A store is absorbed into the buffer without holding the core
          w_stall      = ~MemWriteM;
`else
          w_stall      = 1'b1;
`endif
        end
      end
      S_REQ: begin
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
        // While a posted store drains, only a newly arriving access stalls
        w_stall = r_we ? w_access : 1'b1;
`else
        w_stall = 1'b1;
`endif
        if (bus_req_ready) begin
          if (r_we) begin
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
            w_state_next = S_IDLE;
`else
            w_state_next = S_DONE;
`endif
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = '0;
          end
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (bus_resp_valid) begin
          w_rd_load    = 1'b1;
          w_state_next = S_DONE;
        end else if (w_cnt_inc == CNT_W'(RESP_TIMEOUT)) begin
          w_timeout    = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      default: begin
        // DONE: one un-stalled cycle, never relaunches from held inputs
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request registers, wait counter, load data and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_cnt_next;
      if (w_capture) begin
        r_we    <= MemWriteM;
        r_addr  <= {ALUResultM[31:2], 2'b00};
        r_wdata <= WriteDataM;
        r_be    <= byteEnable;
      end
      if (w_rd_load) begin
        r_rd_data <= bus_resp_rdata;
      end else if (w_timeout) begin
        r_rd_data <= 32'h0;
        r_err     <= 1'b1;
      end
    end
  end

  assign MemStall      = w_stall & ~reset;
  assign bus_req_valid = (r_state == S_REQ);
  assign bus_req_we    = r_we;
  assign bus_req_addr  = r_addr;
  assign bus_req_wdata = r_wdata;
  assign bus_req_be    = r_be;
  assign RD_data       = r_rd_data;
  assign bus_err       = r_err;

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter RESP_TIMEOUT, default 1023, SHALL set the maximum number of WAIT-state cycles before a load is aborted.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemReadM  input  1  core M-stage load request.
REQ-005 MemWriteM  input  1  core M-stage store request.
REQ-006 ALUResultM  input  32  byte address of the access.
REQ-007 WriteDataM  input  32  store data, already lane-aligned.
REQ-008 byteEnable  input  4  store byte lanes.
REQ-009 RD_data  output  32  load word returned to the core, raw and unextended.
REQ-010 MemStall  output  1  holds the core's F, D, E and M stages while high.
REQ-011 bus_req_valid / bus_req_ready  output / input  1 / 1  request handshake.
REQ-012 bus_req_we  output  1  request is a write.
REQ-013 bus_req_addr  output  32  word-aligned address, with bits [1:0] forced to 0.
REQ-014 bus_req_wdata / bus_req_be  output  32 / 4  write data and write byte lanes.
REQ-015 bus_resp_valid / bus_resp_rdata  input  1 / 32  read response.
REQ-016 bus_err  output  1  sticky load-timeout flag.

Function
REQ-017 The FSM SHALL use exactly the states IDLE, REQ, WAIT and DONE.
REQ-018 In IDLE with MemReadM or MemWriteM high, the block SHALL capture the address, data, byte lanes and direction into request registers and move to REQ; MemWriteM SHALL win when both are high.
REQ-019 MemStall SHALL be combinational: high in IDLE when an access is present, and high in REQ and WAIT; it SHALL be low in DONE.
REQ-020 In REQ, bus_req_valid SHALL be 1 and the request outputs SHALL stay stable until bus_req_ready is sampled high.
REQ-021 On a REQ handshake, a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-022 In WAIT, bus_resp_valid SHALL latch bus_resp_rdata into RD_data and move the FSM to DONE; bus_resp_valid outside WAIT SHALL be ignored.
REQ-023 DONE SHALL last exactly one cycle with MemStall low, SHALL return to IDLE, and SHALL NOT launch a new request from the still-present M-stage inputs.
REQ-024 Minimum load latency SHALL be 3 stall cycles: access seen, REQ with ready, response in the cycle after.
REQ-025 A WAIT-cycle counter SHALL clear on entry to WAIT.
REQ-026 When the WAIT-cycle counter reaches RESP_TIMEOUT, RD_data SHALL become 32'h0, bus_err SHALL set, and the FSM SHALL go to DONE.
REQ-027 bus_err SHALL clear only on reset.
REQ-028 RD_data SHALL hold its last value until the next load completes.

Reset
REQ-029 Reset SHALL force: state IDLE, bus_req_valid 0, MemStall 0, RD_data 0, bus_err 0, counters 0, request registers 0.
REQ-030 Reset mid-transaction SHALL abandon the transaction: bus_req_valid SHALL be 0 in the cycle after reset, and any later bus_resp_valid SHALL be ignored.

Configuration
REQ-031 With DMEM_BRIDGE_POSTED_WRITE_EN defined:
- A store seen in IDLE SHALL load a 1-entry write buffer with MemStall low that cycle.
- The buffer SHALL drain through REQ, then return directly to IDLE without DONE.
- Any access arriving while the buffer is occupied SHALL stall until the buffer drains and the FSM is back in IDLE.
REQ-032 Without DMEM_BRIDGE_POSTED_WRITE_EN, stores SHALL stall through REQ and DONE exactly like loads, and no write buffer SHALL exist.

Verification
REQ-033 Load, addr 0x1006, ready=1, response 0xCAFEBABE one cycle later -> bus_req_addr 0x1004; MemStall high 3 cycles; RD_data 0xCAFEBABE in DONE.
REQ-034 Store, addr 0x20, data 0x11223344, be 4'b1100, ready held low 4 cycles -> request outputs stable all 4 cycles; handshake on cycle 5; DONE one cycle later (macro off).
REQ-035 Load with no response, RESP_TIMEOUT=8 -> DONE after 8 WAIT cycles; RD_data 0; bus_err 1 and stays 1 until reset.
REQ-036 Reset asserted during WAIT, response arriving 2 cycles after reset -> IDLE; RD_data stays 0; no new request is issued.
REQ-037 Macro on: store followed immediately by a load, ready=1 -> store costs 0 stall cycles; load stalls until the buffer drains; bus shows the write before the read.
REQ-038 Spurious bus_resp_valid in IDLE with MemReadM and MemWriteM both high -> response ignored; bus_req_we=1.
